sfu_lanes: RTL and testbench
============================

Name: sfu_lanes

Overview:
Parametrised successor to the single-column accumulate/ReLU special function unit, with runtime-selectable SIMD lane split of 1, 2 or 4 lanes. Accumulates a programmed number of partial-sum words per lane, with no carry between lanes and per-lane signed saturation. Optionally applies per-lane ReLU, then presents the result through a valid/ready handshake. Sits between the PE-array output FIFO and the output SRAM write path, one instance per column.

Parameters:
psum_bw, 16, total partial-sum word width; must be divisible by max_lanes
max_lanes, 4, maximum SIMD lanes (1, 2 or 4); lane width = psum_bw / active lanes
cnt_bw, 8, width of the accumulation length counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
mode  input  2  lane select: 0 = 1 lane, 1 = 2 lanes, 2 = 4 lanes, 3 = reserved (behaves as 0); sampled on start
start  input  1  begin a new accumulation job; honoured in IDLE only
len  input  cnt_bw  number of input words to accumulate; sampled on start
relu_en  input  1  apply per-lane ReLU after accumulation; sampled on start
in_valid  input  1  input word valid
in  input  psum_bw  packed signed lanes, lane 0 in the LSBs
in_ready  output  1  high in ACC state only
out  output  psum_bw  accumulator register, packed lanes
out_valid  output  1  result valid, high in OUT state only
out_ready  input  1  downstream accepts the result
busy  output  1  high in any state other than IDLE
sat_flag  output  1  sticky: any lane saturated during the current job

Behaviour:
- Reset (async, active-high): state = IDLE; psum register = 0; out = 0; in_ready, out_valid, busy and sat_flag = 0; latched mode, len and relu_en cleared.
- Active lane count L = 2^mode. If the selected count exceeds max_lanes, L clamps to max_lanes. Mode 3 gives L = 1. Lane width W = psum_bw / L.
- State machine states: IDLE, ACC, RELU, OUT.
  - IDLE, start=1, len>0: psum cleared to 0; sat_flag cleared; counter loaded with len; mode and relu_en latched; next state ACC.
  - IDLE, start=1, len=0: psum cleared; sat_flag cleared; next state OUT (result 0).
  - ACC: in_ready=1. A word is accepted on a cycle with in_valid=1.
    - On acceptance, each lane gets psum_lane <= sat(psum_lane + in_lane), computed at W+1 bits and clamped to [-2^(W-1), 2^(W-1)-1]. No carry crosses a lane boundary.
    - On acceptance, the counter decrements.
    - On acceptance of the last word (counter=1): next state is RELU if relu_en was latched, else OUT.
  - RELU: exactly one cycle; each lane <= (lane < 0) ? 0 : lane; next state OUT.
  - OUT: out_valid=1, out held stable; on out_ready=1, next state IDLE. out keeps its value in IDLE until the next start.
- Latency:
  - last accepted input to out_valid: 1 cycle without ReLU, 2 cycles with ReLU.
  - start to in_ready: 1 cycle.
- start while busy is ignored. Changes to mode, len or relu_en mid-job have no effect.
- in_valid while not in ACC is ignored; no word is consumed.
- sat_flag is set in the same cycle as the saturating accumulate, and holds until the next accepted start or reset.
- Reset mid-job aborts immediately to the reset values; no partial result is presented.
- Lane packing is selected per job, so consecutive jobs may use different modes.

Optional Feature:
SFU_SAT_EN
- Defined: per-lane saturating add and sat_flag behave as described above.
- Undefined: per-lane add wraps modulo 2^W, still with no inter-lane carry. sat_flag is tied to 0.

Test Plan:
- Mode 0, len=3, relu_en=0, inputs 100, -50, 7 -> out=57 (16'h0039), out_valid 1 cycle after third accept, sat_flag=0.
- Mode 1, len=2, inputs 16'h7001 twice -> hi lane 0x70+0x70 saturates to 0x7F, lo = 0x02.
  - SFU_SAT_EN defined: out=16'h7F02, sat_flag=1.
  - SFU_SAT_EN undefined: out=16'hE002, sat_flag=0.
- Mode 2, len=1, relu_en=1, input 16'hF123 -> lane 3 (-1) clamped to 0 -> out=16'h0123, out_valid 2 cycles after accept.
- Backpressure: complete a job, hold out_ready=0 for 5 cycles and pulse start and in_valid -> out and out_valid stable, no state change. out_ready=1 -> IDLE next cycle, busy=0.
- len=0 start -> OUT the next cycle with out=0. Mode 3 with inputs 16'h00FF, 16'h0001, len=2 -> out=16'h0100, carry crosses bit 7 as in 1-lane mode.
- Assert reset asynchronously mid-ACC after 2 of 4 words -> out=0, busy=0, in_ready=0 immediately. A new job afterwards accumulates from 0.

Source files
------------

// File: rtl/sfu_lanes.sv
// sfu_lanes: accumulate/ReLU special function unit with runtime 1/2/4 SIMD lane split.
// Define SFU_SAT_EN for per-lane signed saturation and sat_flag; otherwise lanes wrap.
module sfu_lanes #(
  parameter int psum_bw   = 16,
  parameter int max_lanes = 4,
  parameter int cnt_bw    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic [cnt_bw-1:0]  len,
  input  logic               relu_en,
  input  logic               in_valid,
  input  logic [psum_bw-1:0] in,
  output logic               in_ready,
  output logic [psum_bw-1:0] out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               sat_flag
);
  typedef enum logic [1:0] {IDLE, ACC, RELU, OUT} state_t;
  localparam logic [1:0] LMAX = max_lanes >= 4 ? 2'd2 : max_lanes >= 2 ? 2'd1 : 2'd0;
  state_t             state_q, state_d;
  logic [psum_bw-1:0] psum_q, psum_d, acc_sel, rel_sel;
  logic [cnt_bw-1:0]  cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d, mode_s;
  logic               relu_q, relu_d;
  logic               sat_q, sat_d, sat_sel;
  // One adder/ReLU bank per lane split; the latched mode picks which bank feeds psum.
  for (genvar g = 0; g < 3; g++) begin : gm
    localparam int n = 1 << g;
    localparam int w = psum_bw / n;
    logic [psum_bw-1:0] acc, rel;
    logic               sat;
`ifdef SFU_SAT_EN
    logic [w:0]         s;
`endif
    always_comb begin
      acc = psum_q;
      rel = psum_q;
      sat = 1'b0;
`ifdef SFU_SAT_EN
      s = '0;
`endif
      for (int l = 0; l < n; l++) begin
`ifdef SFU_SAT_EN
        s = {psum_q[l*w+w-1], psum_q[l*w+:w]} + {in[l*w+w-1], in[l*w+:w]};
        acc[l*w+:w] = (s[w] != s[w-1]) ? {s[w], {(w-1){~s[w]}}} : s[w-1:0];
        sat = sat | (s[w] != s[w-1]);
`else
        acc[l*w+:w] = psum_q[l*w+:w] + in[l*w+:w];
`endif
        rel[l*w+:w] = psum_q[l*w+w-1] ? {w{1'b0}} : psum_q[l*w+:w];
      end
    end
  end
  assign acc_sel = mode_q == 2'd2 ? gm[2].acc : mode_q == 2'd1 ? gm[1].acc : gm[0].acc;
  assign rel_sel = mode_q == 2'd2 ? gm[2].rel : mode_q == 2'd1 ? gm[1].rel : gm[0].rel;
`ifdef SFU_SAT_EN
  assign sat_sel = mode_q == 2'd2 ? gm[2].sat : mode_q == 2'd1 ? gm[1].sat : gm[0].sat;
`else
  assign sat_sel = 1'b0;
`endif
  assign mode_s = mode == 2'd3 ? 2'd0 : (mode > LMAX ? LMAX : mode);
  always_comb begin
    state_d = state_q;
    psum_d  = psum_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    relu_d  = relu_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: if (start) begin
        psum_d  = '0;
        cnt_d   = len;
        mode_d  = mode_s;
        relu_d  = relu_en;
        sat_d   = 1'b0;
        state_d = len == '0 ? OUT : ACC;
      end
      ACC: if (in_valid) begin
        psum_d = acc_sel;
        cnt_d  = cnt_q - cnt_bw'(1);
        sat_d  = sat_q | sat_sel;
        if (cnt_q == cnt_bw'(1)) state_d = relu_q ? RELU : OUT;
      end
      RELU: begin
        psum_d  = rel_sel;
        state_d = OUT;
      end
      default: if (out_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      psum_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      relu_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      psum_q  <= psum_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      relu_q  <= relu_d;
      sat_q   <= sat_d;
    end
  end
  assign out       = psum_q;
  assign in_ready  = state_q == ACC;
  assign out_valid = state_q == OUT;
  assign busy      = state_q != IDLE;
  assign sat_flag  = sat_q;
endmodule

// File: tb/tb_sfu_lanes.sv
// tb_sfu_lanes: directed self-checking bench for sfu_lanes (default 16-bit, 4-lane build).
module tb_sfu_lanes;
  logic        clk = 1'b0, reset = 1'b1;
  logic [1:0]  mode = '0;
  logic        start = 1'b0, relu_en = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  len = '0;
  logic [15:0] din = '0, dout;
  logic        in_ready, out_valid, busy, sat_flag;
  int          n_cmp = 0, n_bad = 0;
  sfu_lanes dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .len(len), .relu_en(relu_en),
    .in_valid(in_valid), .in(din), .in_ready(in_ready), .out(dout), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .sat_flag(sat_flag)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic start_job(input logic [1:0] m, input logic [7:0] l, input logic r);
    mode = m; len = l; relu_en = r; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  task automatic feed(input logic [15:0] w);
    in_valid = 1'b1; din = w;
    tick(1);
    in_valid = 1'b0;
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask
  initial begin
    tick(2);
    chk("rst_out", dout, 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_in_ready", 16'(in_ready), 16'h0);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_sat", 16'(sat_flag), 16'h0);
    reset = 1'b0;
    // 1 lane: 100 - 50 + 7 = 57
    start_job(2'd0, 8'd3, 1'b0);
    chk("t1_in_ready", 16'(in_ready), 16'h1);
    chk("t1_busy", 16'(busy), 16'h1);
    feed(16'd100);
    feed(16'hFFCE);
    chk("t1_not_done", 16'(out_valid), 16'h0);
    feed(16'd7);
    chk("t1_out_valid", 16'(out_valid), 16'h1);
    chk("t1_out", dout, 16'h0039);
    chk("t1_sat", 16'(sat_flag), 16'h0);
    release_out();
    chk("t1_idle_busy", 16'(busy), 16'h0);
    chk("t1_idle_hold", dout, 16'h0039);
    // 2 lanes: high byte overflows
    start_job(2'd1, 8'd2, 1'b0);
    feed(16'h7001);
    feed(16'h7001);
    chk("t2_out_valid", 16'(out_valid), 16'h1);
`ifdef SFU_SAT_EN
    chk("t2_out", dout, 16'h7F02);
    chk("t2_sat", 16'(sat_flag), 16'h1);
`else
    chk("t2_out", dout, 16'hE002);
    chk("t2_sat", 16'(sat_flag), 16'h0);
`endif
    release_out();
    // 4 lanes with ReLU: lane 3 = -1 clamps to 0, two-cycle latency
    start_job(2'd2, 8'd1, 1'b1);
    feed(16'hF123);
    chk("t3_relu_cycle", 16'(out_valid), 16'h0);
    chk("t3_relu_busy", 16'(busy), 16'h1);
    tick(1);
    chk("t3_out_valid", 16'(out_valid), 16'h1);
    chk("t3_out", dout, 16'h0123);
    // backpressure: start and in_valid pulses ignored while holding OUT
    out_ready = 1'b0; start = 1'b1; in_valid = 1'b1; din = 16'hFFFF; mode = 2'd0; len = 8'd5;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("bp_out", dout, 16'h0123);
      chk("bp_out_valid", 16'(out_valid), 16'h1);
      chk("bp_in_ready", 16'(in_ready), 16'h0);
    end
    start = 1'b0; in_valid = 1'b0;
    release_out();
    chk("bp_idle_busy", 16'(busy), 16'h0);
    chk("bp_idle_valid", 16'(out_valid), 16'h0);
    // len = 0 goes straight to OUT with a zero result
    start_job(2'd0, 8'd0, 1'b0);
    chk("len0_out_valid", 16'(out_valid), 16'h1);
    chk("len0_out", dout, 16'h0000);
    chk("len0_in_ready", 16'(in_ready), 16'h0);
    release_out();
    // mode 3 behaves as a single 16-bit lane: carry crosses bit 7
    start_job(2'd3, 8'd2, 1'b0);
    feed(16'h00FF);
    feed(16'h0001);
    chk("m3_out_valid", 16'(out_valid), 16'h1);
    chk("m3_out", dout, 16'h0100);
    chk("m3_sat", 16'(sat_flag), 16'h0);
    release_out();
    // async reset midway through a 4-word job
    start_job(2'd0, 8'd4, 1'b0);
    feed(16'd1);
    feed(16'd2);
    chk("ar_pre_out", dout, 16'h0003);
    #2 reset = 1'b1;
    #1;
    chk("ar_out", dout, 16'h0000);
    chk("ar_busy", 16'(busy), 16'h0);
    chk("ar_in_ready", 16'(in_ready), 16'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    start_job(2'd0, 8'd1, 1'b0);
    feed(16'd5);
    chk("ar_new_valid", 16'(out_valid), 16'h1);
    chk("ar_new_out", dout, 16'h0005);
    release_out();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
